// File: rtl/pipe_pkg.sv
// Shared pipeline constants and forwarding-select encodings.
package pipe_pkg;
   localparam int DATA_W = 32;
   localparam int REG_AW = 5;

   typedef enum logic [1:0] {
      FWD_NONE = 2'b00,
      FWD_WB   = 2'b01,
      FWD_HIST = 2'b10
   } fwd_sel_e;
endpackage

// File: rtl/wb_fwd_mux.sv
// Single-operand forwarding compare/select: WB result beats the one-entry history.
// Purely combinational; register 0 never forwards.
module wb_fwd_mux
   import pipe_pkg::*;
#(
   parameter int DATA_W = pipe_pkg::DATA_W,
   parameter int REG_AW = pipe_pkg::REG_AW
) (
   input  logic [REG_AW-1:0] src_i,
   input  logic              wb_we_i,
   input  logic [REG_AW-1:0] wb_addr_i,
   input  logic [DATA_W-1:0] wb_data_i,
   input  logic              hist_v_i,
   input  logic [REG_AW-1:0] hist_addr_i,
   input  logic [DATA_W-1:0] hist_data_i,
   output logic [1:0]        sel_o,
   output logic [DATA_W-1:0] data_o
);
   logic src_nz;

   assign src_nz = (src_i != '0);

   always_comb begin
      sel_o  = FWD_NONE;
      data_o = '0;
      if (src_nz && wb_we_i && (wb_addr_i == src_i)) begin
         sel_o  = FWD_WB;
         data_o = wb_data_i;
      end else if (src_nz && hist_v_i && (hist_addr_i == src_i)) begin
         sel_o  = FWD_HIST;
         data_o = hist_data_i;
      end
   end
endmodule

// File: rtl/wb_stage.sv
// Write-back stage: data select, write qualification, one-entry history, EX forwarding,
// and retire/squash event counters.
module wb_stage
   import pipe_pkg::*;
#(
   parameter int DATA_W = pipe_pkg::DATA_W,
   parameter int REG_AW = pipe_pkg::REG_AW,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] dout_mem,
   input  logic [DATA_W-1:0] result_mem,
   input  logic              MemtoReg_mem,
   input  logic              RegWrite_mem,
   input  logic [REG_AW-1:0] towrite_mem,
   input  logic              valid_mem,
   input  logic              squash,
   input  logic [REG_AW-1:0] src_a,
   input  logic [REG_AW-1:0] src_b,
   output logic [DATA_W-1:0] wb_data,
   output logic [REG_AW-1:0] wb_addr,
   output logic              wb_we,
   output logic [1:0]        fwd_sel_a,
   output logic [DATA_W-1:0] fwd_data_a,
   output logic [1:0]        fwd_sel_b,
   output logic [DATA_W-1:0] fwd_data_b,
   output logic [CNT_W-1:0]  retire_cnt,
   output logic [CNT_W-1:0]  squash_cnt
);
   logic              hist_v_q;
   logic [REG_AW-1:0] hist_addr_q;
   logic [DATA_W-1:0] hist_data_q;
   logic [CNT_W-1:0]  retire_q, retire_d;
   logic [CNT_W-1:0]  squash_q, squash_d;

   assign wb_data = MemtoReg_mem ? dout_mem : result_mem;
   assign wb_addr = towrite_mem;
   // rst_n gates the enable so an in-flight write cannot escape during reset.
   assign wb_we   = rst_n & valid_mem & RegWrite_mem & ~squash & (towrite_mem != '0);

   always_comb begin
      retire_d = retire_q;
      squash_d = squash_q;
      if (valid_mem && !squash) retire_d = retire_q + CNT_W'(1);
      if (valid_mem && squash)  squash_d = squash_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_v_q    <= 1'b0;
         hist_addr_q <= '0;
         hist_data_q <= '0;
         retire_q    <= '0;
         squash_q    <= '0;
      end else begin
         hist_v_q    <= wb_we;
         hist_addr_q <= wb_addr;
         hist_data_q <= wb_data;
         retire_q    <= retire_d;
         squash_q    <= squash_d;
      end
   end

   assign retire_cnt = retire_q;
   assign squash_cnt = squash_q;

   wb_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_a (
      .src_i       (src_a),
      .wb_we_i     (wb_we),
      .wb_addr_i   (wb_addr),
      .wb_data_i   (wb_data),
      .hist_v_i    (hist_v_q),
      .hist_addr_i (hist_addr_q),
      .hist_data_i (hist_data_q),
      .sel_o       (fwd_sel_a),
      .data_o      (fwd_data_a)
   );

   wb_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_b (
      .src_i       (src_b),
      .wb_we_i     (wb_we),
      .wb_addr_i   (wb_addr),
      .wb_data_i   (wb_data),
      .hist_v_i    (hist_v_q),
      .hist_addr_i (hist_addr_q),
      .hist_data_i (hist_data_q),
      .sel_o       (fwd_sel_b),
      .data_o      (fwd_data_b)
   );
endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed literal checks plus randomized traffic against a behavioural model.
module tb_wb_stage;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] dout_mem, result_mem;
   logic        MemtoReg_mem, RegWrite_mem, valid_mem, squash;
   logic [4:0]  towrite_mem, src_a, src_b;
   logic [31:0] wb_data, fwd_data_a, fwd_data_b;
   logic [4:0]  wb_addr;
   logic        wb_we;
   logic [1:0]  fwd_sel_a, fwd_sel_b;
   logic [31:0] retire_cnt, squash_cnt;
   logic [31:0] w_data, w_fa, w_fb;
   logic [4:0]  w_addr;
   logic        w_we;
   logic [1:0]  w_sa, w_sb;
   logic [3:0]  w_ret, w_sq;

   int total = 0;
   int bad   = 0;

   // Model state: last architecturally committed write and event tallies.
   logic        m_hv;
   logic [4:0]  m_ha;
   logic [31:0] m_hd;
   logic [31:0] m_ret, m_sq;

   always #5 clk = ~clk;

   wb_stage dut (
      .clk(clk), .rst_n(rst_n), .dout_mem(dout_mem), .result_mem(result_mem),
      .MemtoReg_mem(MemtoReg_mem), .RegWrite_mem(RegWrite_mem), .towrite_mem(towrite_mem),
      .valid_mem(valid_mem), .squash(squash), .src_a(src_a), .src_b(src_b),
      .wb_data(wb_data), .wb_addr(wb_addr), .wb_we(wb_we),
      .fwd_sel_a(fwd_sel_a), .fwd_data_a(fwd_data_a),
      .fwd_sel_b(fwd_sel_b), .fwd_data_b(fwd_data_b),
      .retire_cnt(retire_cnt), .squash_cnt(squash_cnt)
   );

   wb_stage #(.CNT_W(4)) dut_w (
      .clk(clk), .rst_n(rst_n), .dout_mem(dout_mem), .result_mem(result_mem),
      .MemtoReg_mem(MemtoReg_mem), .RegWrite_mem(RegWrite_mem), .towrite_mem(towrite_mem),
      .valid_mem(valid_mem), .squash(squash), .src_a(src_a), .src_b(src_b),
      .wb_data(w_data), .wb_addr(w_addr), .wb_we(w_we),
      .fwd_sel_a(w_sa), .fwd_data_a(w_fa),
      .fwd_sel_b(w_sb), .fwd_data_b(w_fb),
      .retire_cnt(w_ret), .squash_cnt(w_sq)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic m_we();
      return rst_n && valid_mem && RegWrite_mem && !squash && (towrite_mem != 5'd0);
   endfunction

   function automatic logic [31:0] m_data();
      return MemtoReg_mem ? dout_mem : result_mem;
   endfunction

   function automatic logic [33:0] m_fwd(input logic [4:0] src);
      if (src != 0 && m_we() && towrite_mem == src) return {2'b01, m_data()};
      if (src != 0 && m_hv && m_ha == src)           return {2'b10, m_hd};
      return 34'd0;
   endfunction

   always @(negedge rst_n) begin
      m_hv = 1'b0; m_ha = '0; m_hd = '0; m_ret = '0; m_sq = '0;
   end

   always @(posedge clk) begin
      if (!rst_n) begin
         m_hv = 1'b0; m_ha = '0; m_hd = '0; m_ret = '0; m_sq = '0;
      end else begin
         if (valid_mem && !squash) m_ret = m_ret + 1;
         if (valid_mem && squash)  m_sq  = m_sq + 1;
         m_hv = m_we(); m_ha = towrite_mem; m_hd = m_data();
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      logic [33:0] fa, fb;
      if (rst_n !== 1'bx) begin
         fa = m_fwd(src_a);
         fb = m_fwd(src_b);
         chk("m_wb_we", {31'd0, wb_we}, {31'd0, m_we()});
         chk("m_wb_data", wb_data, m_data());
         chk("m_wb_addr", {27'd0, wb_addr}, {27'd0, towrite_mem});
         chk("m_sel_a", {30'd0, fwd_sel_a}, {30'd0, fa[33:32]});
         chk("m_data_a", fwd_data_a, fa[31:0]);
         chk("m_sel_b", {30'd0, fwd_sel_b}, {30'd0, fb[33:32]});
         chk("m_data_b", fwd_data_b, fb[31:0]);
         chk("m_retire", retire_cnt, m_ret);
         chk("m_squash", squash_cnt, m_sq);
         chk("m_retire_w4", {28'd0, w_ret}, {28'd0, m_ret[3:0]});
         chk("m_squash_w4", {28'd0, w_sq}, {28'd0, m_sq[3:0]});
      end
   end

   task automatic set_in(input logic v, input logic rw, input logic m2r, input logic sq,
                         input logic [4:0] dst, input logic [31:0] dout, input logic [31:0] res,
                         input logic [4:0] sa, input logic [4:0] sb);
      valid_mem = v; RegWrite_mem = rw; MemtoReg_mem = m2r; squash = sq;
      towrite_mem = dst; dout_mem = dout; result_mem = res; src_a = sa; src_b = sb;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick(); tick();
      chk("rst_we", {31'd0, wb_we}, 32'd0);
      chk("rst_retire", retire_cnt, 32'd0);
      chk("rst_squash", squash_cnt, 32'd0);

      // Reset asserted mid-stream with a live write to r5.
      rst_n = 1'b1;
      set_in(1, 1, 0, 0, 5, 0, 32'hAA, 0, 0);
      tick(); tick();
      chk("pre_rst_retire", retire_cnt, 32'd2);
      rst_n = 1'b0;
      #1;
      chk("midrst_we", {31'd0, wb_we}, 32'd0);
      chk("midrst_retire", retire_cnt, 32'd0);
      tick();
      rst_n = 1'b1;
      set_in(0, 0, 0, 0, 0, 0, 0, 5, 5);
      #1;
      chk("midrst_hist_clr", {30'd0, fwd_sel_a}, 32'd0);
      set_in(1, 1, 0, 0, 2, 0, 32'h5, 0, 0);
      tick();
      chk("post_rst_retire", retire_cnt, 32'd1);

      // Load vs result select.
      set_in(1, 1, 1, 0, 3, 32'hDEADBEEF, 32'h00001234, 0, 0);
      #1;
      chk("sel_load", wb_data, 32'hDEADBEEF);
      chk("sel_load_we", {31'd0, wb_we}, 32'd1);
      MemtoReg_mem = 1'b0;
      #1;
      chk("sel_result", wb_data, 32'h00001234);
      tick();

      // r0 guard.
      set_in(1, 1, 0, 0, 0, 0, 32'h77, 0, 0);
      #1;
      chk("r0_we", {31'd0, wb_we}, 32'd0);
      chk("r0_sel_a", {30'd0, fwd_sel_a}, 32'd0);
      tick();
      chk("r0_retire", retire_cnt, 32'd3);

      // WB beats history; history then ages out.
      set_in(1, 1, 0, 0, 7, 0, 32'h11, 0, 0);
      tick();
      set_in(1, 1, 0, 0, 7, 0, 32'h22, 7, 7);
      #1;
      chk("prio_sel_a", {30'd0, fwd_sel_a}, 32'd1);
      chk("prio_sel_b", {30'd0, fwd_sel_b}, 32'd1);
      chk("prio_data_a", fwd_data_a, 32'h22);
      chk("prio_data_b", fwd_data_b, 32'h22);
      tick();
      set_in(0, 0, 0, 0, 0, 0, 0, 7, 0);
      #1;
      chk("hist_sel_a", {30'd0, fwd_sel_a}, 32'd2);
      chk("hist_data_a", fwd_data_a, 32'h22);
      tick();
      chk("aged_sel_a", {30'd0, fwd_sel_a}, 32'd0);
      chk("aged_retire", retire_cnt, 32'd5);

      // Squash three valid writes to r9.
      for (int i = 0; i < 3; i++) begin
         set_in(1, 1, 0, 1, 9, 0, 32'h99 + i, 0, 9);
         #1;
         chk("sq_we", {31'd0, wb_we}, 32'd0);
         chk("sq_sel_b", {30'd0, fwd_sel_b}, 32'd0);
         tick();
      end
      chk("sq_cnt", squash_cnt, 32'd3);
      chk("sq_retire", retire_cnt, 32'd5);

      // 17 retires from zero on the 4-bit counter instance.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 17; i++) begin
         set_in(1, i[0], 0, 0, 5'(i), 0, i, 0, 0);
         tick();
      end
      chk("wrap_w4", {28'd0, w_ret}, 32'd1);
      chk("wrap_w32", retire_cnt, 32'd17);

      // Randomized traffic, small register range to provoke hits.
      for (int i = 0; i < 3000; i++) begin
         rst_n = ($urandom_range(0, 99) != 0);
         set_in($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 1'($urandom),
                $urandom_range(0, 4) == 0, 5'($urandom_range(0, 7)), $urandom, $urandom,
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         tick();
      end
      rst_n = 1'b1;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
